// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
// Optional symmetric-coefficient folding is enabled with `define FIR_SEQ_SYM_EN.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int NUM_TAPS_DEF = 10;
  localparam int TAP_W_DEF    = 4;
  localparam int RD_LAT_DEF   = 1;
  localparam int SEQ_LAT      = NUM_TAPS_DEF + RD_LAT_DEF + 3;

  // Symmetric filters store only the first half of the coefficients.
  function automatic int fold_tap(input int k, input int num_taps);
    return (k < (num_taps + 1) / 2) ? k : (num_taps - 1 - k);
  endfunction

endpackage

// File: rtl/fir_seq_align_pipe.sv
// Delays {valid, tap} by the coefficient RAM read latency to produce the
// multiplier enable and tap select, plus one more stage for the accumulator.
module fir_seq_align_pipe #(
  parameter int TAP_W = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAP_W-1:0] in_tap,
  output logic             out_en_mul,
  output logic [TAP_W-1:0] out_tap,
  output logic             out_en_acc
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [TAP_W-1:0] tap_q [DEPTH];
  logic [TAP_W-1:0] tap_d [DEPTH];
  logic             acc_q, acc_d;

  // Tap fields only load with a valid entry so the last tap index is held.
  always_comb begin
    vld_d[0] = in_valid;
    tap_d[0] = in_valid ? in_tap : tap_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tap_d[i] = vld_q[i-1] ? tap_q[i-1] : tap_q[i];
    end
    acc_d = vld_q[DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= tap_d[i];
    end
  end

  assign out_en_mul = vld_q[DEPTH-1];
  assign out_tap    = tap_q[DEPTH-1];
  assign out_en_acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed control sequencer for the FIR MAC datapath.
// `define FIR_SEQ_SYM_EN folds coefficient addresses for symmetric filters.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int TAP_W    = TAP_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic             iClk12M,
  input  logic             iRst,
  input  logic             iInValid,
  output logic             oInReady,
  input  logic             iOverrunClr,
  output logic             oEnDelay,
  output logic             oCoeffRdEn,
  output logic [TAP_W-1:0] oCoeffAddr,
  output logic [TAP_W-1:0] oTapSel,
  output logic             oEnMul,
  output logic             oAccClr,
  output logic             oEnAcc,
  output logic             oOutValid,
  output logic             oBusy,
  output logic             oOverrun
);

  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] DRAIN_END = TAP_W'(RD_LAT);

  seq_state_e       state_q, state_d;
  logic [TAP_W-1:0] k_q, k_d;
  logic [TAP_W-1:0] addr_q, addr_d;
  logic             in_ready_q, in_ready_d;
  logic             en_delay_q, en_delay_d;
  logic             rd_en_q, rd_en_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // k counts taps in ISSUE and is reused as the drain counter in DRAIN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (iInValid) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        state_d = ISSUE;
        k_d     = '0;
      end
      ISSUE: begin
        if (k_q == LAST_TAP) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      DRAIN: begin
        if (k_q == DRAIN_END) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    en_delay_d  = (state_d == SHIFT);
    rd_en_d     = (state_d == ISSUE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);

    if (rd_en_d) begin
`ifdef FIR_SEQ_SYM_EN
      addr_d = TAP_W'(fold_tap(int'(k_d), NUM_TAPS));
`else
      addr_d = k_d;
`endif
    end else begin
      addr_d = addr_q;
    end

    if (iInValid && !in_ready_q) overrun_d = 1'b1;
    else if (iOverrunClr)        overrun_d = 1'b0;
    else                         overrun_d = overrun_q;
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b1;
      en_delay_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      en_delay_q  <= en_delay_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  fir_seq_align_pipe #(
    .TAP_W (TAP_W),
    .DEPTH (RD_LAT)
  ) u_align (
    .clk        (iClk12M),
    .rst        (iRst),
    .in_valid   (rd_en_q),
    .in_tap     (k_q),
    .out_en_mul (oEnMul),
    .out_tap    (oTapSel),
    .out_en_acc (oEnAcc)
  );

  assign oInReady   = in_ready_q;
  assign oEnDelay   = en_delay_q;
  assign oAccClr    = en_delay_q;
  assign oCoeffRdEn = rd_en_q;
  assign oCoeffAddr = addr_q;
  assign oOutValid  = out_valid_q;
  assign oBusy      = busy_q;
  assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fir_mac_sequencer;

  parameter int RD_LAT = 1;
  localparam int NT  = 10;
  localparam int TW  = 4;
  localparam int LAT = NT + RD_LAT + 3;

  logic          clk = 1'b0;
  logic          iRst, iInValid, iOverrunClr;
  logic          oInReady, oEnDelay, oCoeffRdEn, oEnMul, oAccClr, oEnAcc;
  logic          oOutValid, oBusy, oOverrun;
  logic [TW-1:0] oCoeffAddr, oTapSel;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.NUM_TAPS(NT), .TAP_W(TW), .RD_LAT(RD_LAT)) dut (
    .iClk12M(clk), .iRst(iRst), .iInValid(iInValid), .oInReady(oInReady),
    .iOverrunClr(iOverrunClr), .oEnDelay(oEnDelay), .oCoeffRdEn(oCoeffRdEn),
    .oCoeffAddr(oCoeffAddr), .oTapSel(oTapSel), .oEnMul(oEnMul),
    .oAccClr(oAccClr), .oEnAcc(oEnAcc), .oOutValid(oOutValid),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  typedef struct { int cyc; int val; } evt_t;
  evt_t q_dly[$], q_rd[$], q_mul[$], q_acc[$], q_out[$];
  evt_t mon_e;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_from = 1;
  int busy_until = 0;
  bit mon_en = 1'b0;
  int t_acc;

  int addr_tbl [NT];
`ifdef FIR_SEQ_SYM_EN
  initial addr_tbl = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
`else
  initial addr_tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endfunction

  function automatic void unexp(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s @cycle %0d: strobe with no expected entry", nm, cyc);
  endfunction

  function automatic evt_t mk(int c, int v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (oEnDelay || oAccClr) begin
        if (q_dly.size() == 0) unexp("en_delay");
        else begin
          mon_e = q_dly.pop_front();
          chk("en_delay_cycle", cyc, mon_e.cyc);
          chk("en_delay_accclr_pair", int'({oEnDelay, oAccClr}), mon_e.val);
        end
      end
      if (oCoeffRdEn) begin
        if (q_rd.size() == 0) unexp("coeff_rd");
        else begin
          mon_e = q_rd.pop_front();
          chk("coeff_rd_cycle", cyc, mon_e.cyc);
          chk("coeff_addr", int'(oCoeffAddr), mon_e.val);
        end
      end
      if (oEnMul) begin
        if (q_mul.size() == 0) unexp("en_mul");
        else begin
          mon_e = q_mul.pop_front();
          chk("en_mul_cycle", cyc, mon_e.cyc);
          chk("tap_sel", int'(oTapSel), mon_e.val);
        end
      end
      if (oEnAcc) begin
        if (q_acc.size() == 0) unexp("en_acc");
        else begin
          mon_e = q_acc.pop_front();
          chk("en_acc_cycle", cyc, mon_e.cyc);
        end
      end
      if (oOutValid) begin
        if (q_out.size() == 0) unexp("out_valid");
        else begin
          mon_e = q_out.pop_front();
          chk("out_valid_cycle", cyc, mon_e.cyc);
        end
      end
      chk("in_ready", int'(oInReady), (cyc >= busy_from && cyc <= busy_until) ? 0 : 1);
      chk("busy", int'(oBusy), (cyc >= busy_from && cyc <= busy_until) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic send(bit accept);
    iInValid = 1'b1;
    if (accept) begin
      t_acc = cyc;
      q_dly.push_back(mk(t_acc + 1, 3));
      for (int k = 0; k < NT; k++) begin
        q_rd.push_back(mk(t_acc + 2 + k, addr_tbl[k]));
        q_mul.push_back(mk(t_acc + 2 + k + RD_LAT, k));
        q_acc.push_back(mk(t_acc + 3 + k + RD_LAT, 0));
      end
      q_out.push_back(mk(t_acc + LAT, 0));
      busy_from  = t_acc + 1;
      busy_until = t_acc + LAT;
    end
    tick();
    iInValid = 1'b0;
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, "_in_ready"}, int'(oInReady), 1);
    chk({nm, "_strobes"}, int'({oEnDelay, oCoeffRdEn, oEnMul, oAccClr, oEnAcc, oOutValid, oBusy}), 0);
    chk({nm, "_coeff_addr"}, int'(oCoeffAddr), 0);
    chk({nm, "_tap_sel"}, int'(oTapSel), 0);
    chk({nm, "_overrun"}, int'(oOverrun), 0);
  endtask

  int t0;

  initial begin
    iRst = 1'b1;
    iInValid = 1'b0;
    iOverrunClr = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
    tick();
    mon_en = 1'b1;
    chk_idle_outputs("reset");

    // Single sample accepted at cycle 5.
    wait_until(5);
    send(1'b1);
    wait_until(5 + LAT + 2);
    chk("tap_sel_hold", int'(oTapSel), NT - 1);
    chk("overrun_single", int'(oOverrun), 0);

    // Back-to-back samples at the minimum spacing.
    for (int i = 0; i < 20; i++) begin
      send(1'b1);
      repeat (LAT) tick();
    end
    chk("overrun_stream", int'(oOverrun), 0);

    // Sample offered while busy is dropped and flagged.
    t0 = cyc;
    send(1'b1);
    wait_until(t0 + 4);
    send(1'b0);
    wait_until(t0 + LAT + 1);
    chk("overrun_set", int'(oOverrun), 1);
    iOverrunClr = 1'b1;
    tick();
    iOverrunClr = 1'b0;
    chk("overrun_clear", int'(oOverrun), 0);

    // Set and clear in the same cycle: set wins.
    t0 = cyc;
    send(1'b1);
    wait_until(t0 + 3);
    iInValid = 1'b1;
    iOverrunClr = 1'b1;
    tick();
    iInValid = 1'b0;
    iOverrunClr = 1'b0;
    chk("overrun_set_wins", int'(oOverrun), 1);
    wait_until(t0 + LAT + 1);
    iOverrunClr = 1'b1;
    tick();
    iOverrunClr = 1'b0;
    chk("overrun_clear2", int'(oOverrun), 0);

    // Reset in the middle of ISSUE aborts the sequence.
    t0 = cyc;
    send(1'b1);
    wait_until(t0 + 8);
    iRst = 1'b1;
    busy_until = t0 + 8;
    tick();
    q_dly.delete();
    q_rd.delete();
    q_mul.delete();
    q_acc.delete();
    q_out.delete();
    iRst = 1'b0;
    chk_idle_outputs("mid_reset");
    repeat (LAT + 4) tick();
    send(1'b1);
    repeat (LAT + 3) tick();

    chk("left_en_delay", q_dly.size(), 0);
    chk("left_coeff_rd", q_rd.size(), 0);
    chk("left_en_mul", q_mul.size(), 0);
    chk("left_en_acc", q_acc.size(), 0);
    chk("left_out_valid", q_out.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed control for the 10-tap FIR MAC datapath: coefficient SRAM reads, delay-line shift, multiplier enable, accumulator clear/enable.
- Accepts one input-sample strobe per FIR output and issues one output-valid pulse per FIR output.
- Sits between the sample front end and the delay line, coefficient RAM, multiplier and accumulator. Runs on the 12 MHz system clock.

Parameters:
- NUM_TAPS, 10, number of FIR taps sequenced per sample (2..16)
- TAP_W, 4, width of tap index / coefficient address
- RD_LAT, 1, coefficient RAM read latency in cycles (1..3)

Ports:
- iClk12M  in  1  system clock, rising edge
- iRst  in  1  synchronous reset, active-high
- iInValid  in  1  new sample available (level or pulse)
- oInReady  out  1  sequencer can accept a sample
- iOverrunClr  in  1  clears sticky overrun flag
- oEnDelay  out  1  one-cycle delay-line shift pulse
- oCoeffRdEn  out  1  coefficient RAM read strobe
- oCoeffAddr  out  TAP_W  coefficient RAM address
- oTapSel  out  TAP_W  tap index presented with oEnMul
- oEnMul  out  1  multiplier enable, aligned to coefficient data
- oAccClr  out  1  accumulator clear pulse
- oEnAcc  out  1  accumulate registered product
- oOutValid  out  1  one-cycle pulse, FIR result complete
- oBusy  out  1  high in any state but IDLE
- oOverrun  out  1  sticky: sample offered while not ready

Behaviour:
- Reset: synchronous, active-high on iRst. State goes to IDLE. All outputs are 0 except oInReady, which is 1. Tap counter and alignment pipes clear. Reset mid-sequence aborts with no oOutValid.
- States: IDLE -> SHIFT -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - oInReady=1.
  - Accept when iInValid=1 at edge T; go to SHIFT.
- SHIFT (T+1):
  - oEnDelay=1 and oAccClr=1 for exactly one cycle.
  - Go to ISSUE with k=0.
- ISSUE (T+2 .. T+1+NUM_TAPS):
  - oCoeffRdEn=1, oCoeffAddr=k; k increments each cycle.
  - Leave after k=NUM_TAPS-1.
- Alignment pipe: tap k produces oEnMul=1 and oTapSel=k at T+2+k+RD_LAT, then oEnAcc=1 one cycle later.
- DRAIN: RD_LAT+1 cycles, until the last oEnAcc has been issued.
- DONE: oOutValid=1 for one cycle, then IDLE.
- Latency: oOutValid at T+NUM_TAPS+RD_LAT+3 (T+14 at defaults). Minimum accept-to-accept spacing is NUM_TAPS+RD_LAT+4 cycles (15).
- oInReady is 0 in every non-IDLE state. oTapSel holds its last value while oEnMul=0.
- Overrun: iInValid=1 while oInReady=0 sets oOverrun; the sample is dropped and the sequence continues unaffected. iOverrunClr clears the flag; a set in the same cycle wins.
- The tap counter never wraps inside a sequence. Exit is by compare with NUM_TAPS-1, so no count beyond NUM_TAPS-1 is ever issued.

Optional Feature:
- Macro FIR_SEQ_SYM_EN.
- Defined: symmetric-coefficient folding. oCoeffAddr = k for k < ceil(NUM_TAPS/2), else NUM_TAPS-1-k, so only ceil(NUM_TAPS/2) coefficients are stored. oTapSel still runs 0..NUM_TAPS-1.
- Undefined: oCoeffAddr = k for every tap.
- Timing is identical either way.

Decomposition:
- Package fir_seq_pkg holds:
  - State encoding: IDLE, SHIFT, ISSUE, DRAIN, DONE.
  - Default NUM_TAPS, TAP_W, RD_LAT constants.
  - Derived constant SEQ_LAT = NUM_TAPS+RD_LAT+3.
- One sub-module, fir_seq_align_pipe: a parameterised depth-RD_LAT shift register carrying {valid, tap index}. It generates oEnMul/oTapSel, plus a 1-stage extension for oEnAcc.

Test Plan:
- Reset then a single iInValid at cycle 5 -> oEnDelay and oAccClr at 6; oCoeffAddr 0..9 at 7..16; oEnMul with oTapSel 0..9 at 8..17; oEnAcc at 9..18; oOutValid at 19; oInReady back to 1 at 20.
- iInValid every 15 cycles for 20 samples -> exactly 20 oOutValid pulses, each 14 cycles after accept; oOverrun stays 0.
- Second iInValid at T+4 -> dropped, oOverrun=1, single oOutValid at T+14. Then iOverrunClr -> oOverrun=0. iInValid and iOverrunClr in the same cycle while busy -> oOverrun remains 1.
- iRst asserted at T+8 mid-ISSUE -> next cycle all outputs 0, oInReady=1, no oOutValid. A new sample afterwards completes normally.
- RD_LAT=3 build -> oEnMul for tap k at T+5+k; oOutValid at T+16.
- FIR_SEQ_SYM_EN defined -> oCoeffAddr sequence 0,1,2,3,4,4,3,2,1,0 while oTapSel runs 0..9.
